// File: rtl/ingress_arbiter.sv
// Shares the queueing-domain write port between two packetizers. Each input has a small FIFO,
// since packetizers cannot be stalled. A round-robin grant then writes one packet per cycle.

// Generic FIFO. The push test uses the count before any same-cycle pop.
module ingress_arbiter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop_vld,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign w_push     = i_push_vld && !o_full;
  assign w_pop      = i_pop_vld && !o_empty;
  assign o_head_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage is left unreset: the reset count makes any stale entry unreachable.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

module ingress_arbiter #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 102 + (4 * 16) + (4 * 128),
  parameter int BUFFER_DEPTH     = 2,
  parameter int COUNTER_SIZE     = 16,
  localparam int IW = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_SIZE-1:0]        packetizer_1_to_dispatcher_packet,
  input  logic                        packetizer_1_to_dispatcher_valid,
  input  logic [IW-1:0]               packetizer_1_to_dispatcher_id,
  input  logic [DATA_SIZE-1:0]        packetizer_2_to_dispatcher_packet,
  input  logic                        packetizer_2_to_dispatcher_valid,
  input  logic [IW-1:0]               packetizer_2_to_dispatcher_id,
  input  logic [NUMBER_OF_QUEUES-1:0] full,
  output logic [DATA_SIZE-1:0]        arbiter_to_queues_packet,
  output logic [NUMBER_OF_QUEUES-1:0] arbiter_to_queues_valid,
  output logic                        arbiter_to_queues_source,
  output logic [COUNTER_SIZE-1:0]     drop_count_1,
  output logic [COUNTER_SIZE-1:0]     drop_count_2,
  output logic [1:0]                  pending
);
  typedef struct packed {
    logic [IW-1:0]        id;
    logic [DATA_SIZE-1:0] pkt;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [1:0]                  w_in_vld;
  logic [1:0]                  w_empty;
  logic [1:0]                  w_full;
  logic [1:0]                  w_elig;
  logic [1:0]                  w_pop;
  logic [1:0]                  w_drop;
  logic [EW-1:0]               w_in_dat   [2];
  logic [EW-1:0]               w_head_raw [2];
  entry_t                      w_head     [2];
  entry_t                      w_gnt;
  logic                        w_gnt_vld;
  logic                        w_gnt_sel;

  logic                        r_rr;
  logic [NUMBER_OF_QUEUES-1:0] r_valid;
  logic [DATA_SIZE-1:0]        r_packet;
  logic                        r_source;
  logic [COUNTER_SIZE-1:0]     r_drop [2];

  assign w_in_vld    = {packetizer_2_to_dispatcher_valid, packetizer_1_to_dispatcher_valid};
  assign w_in_dat[0] = {packetizer_1_to_dispatcher_id, packetizer_1_to_dispatcher_packet};
  assign w_in_dat[1] = {packetizer_2_to_dispatcher_id, packetizer_2_to_dispatcher_packet};

  for (genvar g = 0; g < 2; g++) begin : g_in
    ingress_arbiter_fifo #(
      .WIDTH (EW),
      .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_push_vld (w_in_vld[g]),
      .i_push_dat (w_in_dat[g]),
      .i_pop_vld  (w_pop[g]),
      .o_head_dat (w_head_raw[g]),
      .o_empty    (w_empty[g]),
      .o_full     (w_full[g])
    );

    assign w_head[g] = entry_t'(w_head_raw[g]);
    assign w_drop[g] = w_in_vld[g] && w_full[g];
    // Last cycle's write stands in for the full flag the queue has not raised yet.
    assign w_elig[g] = !w_empty[g] && !full[w_head[g].id] && !r_valid[w_head[g].id];
  end

  assign w_gnt_vld = |w_elig;
  assign w_gnt_sel = (&w_elig) ? r_rr : w_elig[1];
  assign w_pop     = {w_gnt_vld && w_gnt_sel, w_gnt_vld && !w_gnt_sel};
  assign w_gnt     = w_head[w_gnt_sel];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr     <= 1'b0;
      r_valid  <= '0;
      r_packet <= '0;
      r_source <= 1'b0;
    end else if (w_gnt_vld) begin
      r_rr     <= ~w_gnt_sel;
      r_valid  <= NUMBER_OF_QUEUES'(1) << w_gnt.id;
      r_packet <= w_gnt.pkt;
      r_source <= w_gnt_sel;
    end else begin
      r_valid  <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop[0] <= '0;
      r_drop[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_drop[i] && !(&r_drop[i])) r_drop[i] <= r_drop[i] + COUNTER_SIZE'(1);
      end
    end
  end

  assign arbiter_to_queues_packet = r_packet;
  assign arbiter_to_queues_valid  = r_valid;
  assign arbiter_to_queues_source = r_source;
  assign drop_count_1             = r_drop[0];
  assign drop_count_2             = r_drop[1];
  assign pending                  = ~w_empty;
endmodule

// File: tb/tb_ingress_arbiter.sv
// Testbench for ingress_arbiter: directed scenarios followed by random traffic.
// A queue-based reference model predicts the outputs after every clock edge.
module tb_ingress_arbiter;
  localparam int NQ   = 4;
  localparam int DW   = 102 + (4 * 16) + (4 * 128);
  localparam int BD   = 2;
  localparam int CS   = 4;
  localparam int IW   = 2;
  localparam int CMAX = (1 << CS) - 1;

  logic          clock;
  logic          reset;
  logic [DW-1:0] p1_pkt, p2_pkt;
  logic          p1_vld, p2_vld;
  logic [IW-1:0] p1_id, p2_id;
  logic [NQ-1:0] full;
  logic [DW-1:0] out_pkt;
  logic [NQ-1:0] out_vld;
  logic          out_src;
  logic [CS-1:0] drop1, drop2;
  logic [1:0]    pending;

  int n_checks = 0;
  int n_errors = 0;

  ingress_arbiter #(
    .NUMBER_OF_QUEUES (NQ),
    .DATA_SIZE        (DW),
    .BUFFER_DEPTH     (BD),
    .COUNTER_SIZE     (CS)
  ) dut (
    .clock                             (clock),
    .reset                             (reset),
    .packetizer_1_to_dispatcher_packet (p1_pkt),
    .packetizer_1_to_dispatcher_valid  (p1_vld),
    .packetizer_1_to_dispatcher_id     (p1_id),
    .packetizer_2_to_dispatcher_packet (p2_pkt),
    .packetizer_2_to_dispatcher_valid  (p2_vld),
    .packetizer_2_to_dispatcher_id     (p2_id),
    .full                              (full),
    .arbiter_to_queues_packet          (out_pkt),
    .arbiter_to_queues_valid           (out_vld),
    .arbiter_to_queues_source          (out_src),
    .drop_count_1                      (drop1),
    .drop_count_2                      (drop2),
    .pending                           (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int            id;
    logic [DW-1:0] pkt;
  } ent_t;

  ent_t          m_q1[$];
  ent_t          m_q2[$];
  int            m_rr;
  logic [NQ-1:0] m_valid;
  logic [DW-1:0] m_packet;
  logic          m_source;
  int            m_drop1;
  int            m_drop2;

  // Advance the reference model by one clock edge, using the inputs currently driven.
  task automatic model_edge();
    int   n1, n2, g;
    bit   e1, e2;
    ent_t h;
    if (reset) begin
      m_q1.delete();
      m_q2.delete();
      m_rr = 0; m_valid = '0; m_packet = '0; m_source = 1'b0;
      m_drop1 = 0; m_drop2 = 0;
      return;
    end
    n1 = m_q1.size();
    n2 = m_q2.size();
    e1 = (n1 > 0) && !full[m_q1[0].id] && !m_valid[m_q1[0].id];
    e2 = (n2 > 0) && !full[m_q2[0].id] && !m_valid[m_q2[0].id];
    g = -1;
    if (e1 && e2) g = m_rr;
    else if (e1)  g = 0;
    else if (e2)  g = 1;
    m_valid = '0;
    if (g == 0) h = m_q1.pop_front();
    if (g == 1) h = m_q2.pop_front();
    if (g >= 0) begin
      m_valid[h.id] = 1'b1;
      m_packet      = h.pkt;
      m_source      = (g == 1);
      m_rr          = 1 - g;
    end
    if (p1_vld) begin
      if (n1 < BD) m_q1.push_back('{int'(p1_id), p1_pkt});
      else if (m_drop1 < CMAX) m_drop1++;
    end
    if (p2_vld) begin
      if (n2 < BD) m_q2.push_back('{int'(p2_id), p2_pkt});
      else if (m_drop2 < CMAX) m_drop2++;
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic [1:0] exp_pend;
    exp_pend = {m_q2.size() != 0, m_q1.size() != 0};
    chk("valid",   DW'(out_vld),  DW'(m_valid));
    chk("packet",  out_pkt,       m_packet);
    chk("source",  DW'(out_src),  DW'(m_source));
    chk("drop1",   DW'(drop1),    DW'(m_drop1));
    chk("drop2",   DW'(drop2),    DW'(m_drop2));
    chk("pending", DW'(pending),  DW'(exp_pend));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic drive(input bit v1, input int id1, input logic [DW-1:0] k1,
                       input bit v2, input int id2, input logic [DW-1:0] k2);
    p1_vld = v1; p1_id = IW'(id1); p1_pkt = k1;
    p2_vld = v2; p2_id = IW'(id2); p2_pkt = k2;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_pkt();
    logic [DW-1:0] p;
    p = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) p = {p[DW-33:0], 32'($urandom())};
    return p;
  endfunction

  initial begin
    reset = 1'b1;
    full  = '0;
    idle();
    tick();
    tick();
    chk("rst_valid", DW'(out_vld), '0);
    chk("rst_pend",  DW'(pending), '0);
    reset = 1'b0;

    // Single-packet latency
    drive(1, 2, DW'(8'hA5), 0, 0, '0);
    tick();
    idle();
    tick();
    chk("lat_valid",  DW'(out_vld), DW'(4'b0100));
    chk("lat_packet", out_pkt,      DW'(8'hA5));
    chk("lat_source", DW'(out_src), '0);
    tick();
    chk("lat_one_cycle", DW'(out_vld), '0);

    // Round-robin to distinct queues, then both to queue 3
    do_reset();
    drive(1, 0, DW'(16'h1111), 1, 1, DW'(16'h2222));
    tick();
    idle();
    tick();
    chk("rr_first",  DW'(out_vld), DW'(4'b0001));
    tick();
    chk("rr_second", DW'(out_vld), DW'(4'b0010));
    chk("rr_src2",   DW'(out_src), DW'(1'b1));
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1, 3, DW'(k + 16'h30), 1, 3, DW'(k + 16'h40));
      tick();
    end
    idle();
    for (int k = 0; k < 10; k++) tick();

    // Full-queue bypass
    do_reset();
    full = 4'b0001;
    drive(1, 0, DW'(16'hB0B0), 1, 2, DW'(16'hC2C2));
    tick();
    idle();
    tick();
    chk("byp_valid", DW'(out_vld), DW'(4'b0100));
    chk("byp_pend",  DW'(pending), DW'(2'b01));
    tick();
    tick();
    full = 4'b0000;
    tick();
    chk("byp_release", DW'(out_vld), DW'(4'b0001));
    tick();

    // Overflow with all queues full, then drain in order
    do_reset();
    full = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      drive(1, k % 4, DW'(k + 16'h500), 0, 0, '0);
      tick();
    end
    idle();
    chk("ovf_drop1", DW'(drop1), DW'(3));
    full = 4'b0000;
    for (int k = 0; k < 6; k++) tick();

    // Drop counter saturation
    do_reset();
    full = 4'b1111;
    for (int k = 0; k < 22; k++) begin
      drive(0, 0, '0, 1, 1, DW'(k));
      tick();
    end
    idle();
    chk("sat_drop2", DW'(drop2), DW'(CMAX));
    full = 4'b0000;
    for (int k = 0; k < 4; k++) tick();

    // Mid-operation reset with both FIFOs loaded and a write in flight
    do_reset();
    full = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, DW'(k + 16'h700), 1, 1, DW'(k + 16'h800));
      tick();
    end
    full = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_valid",  DW'(out_vld), '0);
    chk("mrst_packet", out_pkt,      '0);
    chk("mrst_pend",   DW'(pending), '0);
    chk("mrst_drop1",  DW'(drop1),   '0);
    reset = 1'b0;
    idle();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mrst_nowrite", DW'(out_vld), '0);
    end

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int q = 0; q < NQ; q++) full[q] = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 1) == 1, int'($urandom_range(0, NQ - 1)), rand_pkt(),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, NQ - 1)), rand_pkt());
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ingress_arbiter.md
# ingress_arbiter

Shares the single write port of the queueing domain between the two packetizers. Each packetizer gets a small FIFO that absorbs its packets, since packetizers have no back-pressure. A round-robin arbiter then picks one packet per cycle and drives it to the target queue. The arbiter never writes to a queue whose full flag is set, or may be about to be set. The block sits between the packetizers and the queueing domain's `dispatcher_to_queues_packet` / `dispatcher_to_queues_valid` inputs, and replaces the direct single-packetizer connection.

## Interface
- `NUMBER_OF_QUEUES`, 4, number of downstream queues; one-hot write-enable width.
- `DATA_SIZE`, 102+(4*16)+(4*128), packet width in bits.
- `BUFFER_DEPTH`, 2, entries per input FIFO; must be a power of two, ≥1.
- `COUNTER_SIZE`, 16, width of the saturating drop counters.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `packetizer_1_to_dispatcher_packet` input DATA_SIZE: packet from packetizer 1.
- `packetizer_1_to_dispatcher_valid` input 1: packet 1 present this cycle.
- `packetizer_1_to_dispatcher_id` input $clog2(NUMBER_OF_QUEUES): target queue of packet 1.
- `packetizer_2_to_dispatcher_packet`, `packetizer_2_to_dispatcher_valid`, `packetizer_2_to_dispatcher_id`: same as above, for packetizer 2.
- `full` input NUMBER_OF_QUEUES: per-queue full flags from the queueing domain.
- `arbiter_to_queues_packet` output DATA_SIZE: registered packet to write.
- `arbiter_to_queues_valid` output NUMBER_OF_QUEUES: registered one-hot write enable; all-zero means no write.
- `arbiter_to_queues_source` output 1: input granted for the current write (0 = packetizer 1).
- `drop_count_1`, `drop_count_2` output COUNTER_SIZE: packets discarded per input.
- `pending` output 2: bit i set when FIFO i is non-empty.

## Operation
- **Input FIFOs.** Each input has a FIFO of BUFFER_DEPTH entries holding {id, packet}.
  - On a valid cycle, a push occurs iff the FIFO count < BUFFER_DEPTH, evaluated before any same-cycle pop. A pop in the same cycle does not free space for that push.
  - Otherwise the packet is dropped and the drop counter increments, saturating at all-ones.
- **Head eligibility.** A FIFO head is eligible iff:
  - its FIFO is non-empty;
  - `full[id]` is 0;
  - its target queue was not written in the previous cycle, i.e. the previous-cycle `arbiter_to_queues_valid[id]` is 0. This covers the one-cycle lag of the `full` flag.
- **Arbitration.** Round-robin pointer `rr`, reset value 0.
  - If only one head is eligible, grant it.
  - If both are eligible, grant input `rr`.
  - After any grant to input i, `rr` becomes 1-i. With no grant, `rr` is unchanged.
  - An ineligible head blocks only its own FIFO; the other input proceeds (no cross-input head-of-line blocking).
- **Output.** On a grant, at the next edge:
  - the granted head is popped;
  - `arbiter_to_queues_packet` is loaded with the head packet;
  - `arbiter_to_queues_valid` becomes 1 << id;
  - `arbiter_to_queues_source` becomes i.
  - With no grant, `arbiter_to_queues_valid` is cleared to 0, while packet and source hold their previous values.
- **Ordering.** Packets from one input leave in arrival order. There is no ordering guarantee between the two inputs.
- **Reset.** Applies at any time, including mid-operation.
  - FIFOs are emptied and buffered packets discarded.
  - `rr` = 0.
  - All outputs = 0: packet, valid, source, both drop counters, pending.
  - Inputs presented in the reset cycle are ignored and not counted.

## Timing
- Push on edge E; the earliest write appears on the outputs for the cycle following edge E+1 (one full cycle in the FIFO).
- Throughput: at most one write per cycle in total, and at most one write per queue every two cycles.
- `pending` and the drop counters update at the same edge as the push, pop, or drop that changes them.
- `arbiter_to_queues_valid` is asserted for exactly one cycle per granted packet.

## Test plan
- **Single-packet latency.** P1 valid, id=2, packet=0xA5 on one cycle, queues empty → two edges later `valid`=4'b0100, packet=0xA5, source=0, asserted for exactly 1 cycle.
- **Round-robin.** P1 to queue 0 and P2 to queue 1 on the same cycle, after reset → P1 written first (rr=0), P2 on the next cycle.
  - Repeat with both inputs targeting queue 3 → writes in consecutive alternating slots, with a one-cycle gap between writes to queue 3.
- **Full-queue bypass.** `full`=4'b0001; P1 to queue 0, P2 to queue 2 → only P2 written; `pending`=2'b01 while P1 holds.
  - Deassert `full[0]` → P1 written the following cycle.
- **Overflow.** BUFFER_DEPTH=2, `full`=4'b1111; P1 valid for 5 cycles → FIFO holds the first 2 packets, `drop_count_1`=3.
  - Then release `full` → exactly 2 writes, in arrival order.
- **Counter saturation.** COUNTER_SIZE=4, keep P2 overflowing for 20 drops → `drop_count_2` stops at 15.
- **Mid-operation reset.** Assert reset with both FIFOs holding 2 entries and a write in flight → the next cycle shows all outputs 0 and `pending`=0; no buffered packet is ever written after reset.
